// File: rtl/alarm_tone_seq.sv
// alarm_tone_seq: shares one tone generator between a looping alarm melody and a key-click; define ALARM_SEQ_CLICK_EN to build the click path
module alarm_tone_seq #(
  parameter int NUM_STEPS = 8,
  parameter int DIV_W = 16,
  parameter int DUR_W = 16,
  parameter logic [DIV_W-1:0] CLICK_DIV = DIV_W'(500),
  parameter int CLICK_TICKS = 4
) (
  input  logic                          pclk_i,
  input  logic                          prst_i,
  input  logic                          tick_i,
  input  logic                          alarm_req_i,
  input  logic                          click_req_i,
  input  logic                          tbl_we_i,
  input  logic [$clog2(NUM_STEPS)-1:0]  tbl_addr_i,
  input  logic [DIV_W+DUR_W-1:0]        tbl_wdata_i,
  output logic                          tone_en_o,
  output logic [DIV_W-1:0]              tone_div_o,
  output logic                          busy_o,
  output logic                          src_o,
  output logic [$clog2(NUM_STEPS)-1:0]  step_o,
  output logic                          click_drop_o
);
  localparam int AW = $clog2(NUM_STEPS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NOTE = 2'd1;
  localparam logic [1:0] GAP = 2'd2;
  logic [DIV_W+DUR_W-1:0] tbl [NUM_STEPS];
  logic [DIV_W+DUR_W-1:0] ent_c, ent_0, ld_ent;
  logic [1:0] state, ns;
  logic [DUR_W-1:0] cnt, cur_dur;
  logic [AW-1:0] cand;
  logic empty, in_alarm, load, use_c, ld_ok, ns_click, drop_set;
`ifdef ALARM_SEQ_CLICK_EN
  localparam logic [1:0] CLICK = 2'd3;
  logic click_go, click_done;
  assign click_go = state == IDLE && click_req_i && !alarm_req_i;
  assign click_done = state == CLICK && tick_i && cnt == DUR_W'(CLICK_TICKS - 1);
  assign ns_click = ns == CLICK;
  assign drop_set = click_req_i && (state != IDLE || alarm_req_i);
`else
  logic unused_click;
  assign unused_click = ^{click_req_i, CLICK_TICKS};
  assign ns_click = 1'b0;
  assign drop_set = 1'b0;
`endif
  assign in_alarm = state == NOTE || state == GAP;
  // an empty-melody gap keeps re-checking step 0 instead of advancing
  assign cand = (state == GAP && !empty) ? step_o + 1'b1 : '0;
  assign ent_c = tbl[cand];
  assign ent_0 = tbl[0];
  assign use_c = ent_c[DIV_W+:DUR_W] != '0;
  assign ld_ok = use_c || ent_0[DIV_W+:DUR_W] != '0;
  assign ld_ent = use_c ? ent_c : ent_0;
  assign load = alarm_req_i && (in_alarm ? state == GAP && tick_i : 1'b1);
  // next state; alarm start/advance dominates, alarm drop returns to idle
  always_comb begin
    ns = state;
    if (load) ns = ld_ok ? NOTE : GAP;
    else if (in_alarm && !alarm_req_i) ns = IDLE;
    else if (state == NOTE && tick_i && cnt == cur_dur - 1'b1) ns = GAP;
`ifdef ALARM_SEQ_CLICK_EN
    else if (click_done) ns = IDLE;
    else if (click_go) ns = CLICK;
`endif
  end
  // note table; a same-cycle load reads the pre-write contents
  always_ff @(posedge pclk_i) begin
    if (prst_i) for (int i = 0; i < NUM_STEPS; i++) tbl[i] <= '0;
    else if (tbl_we_i) tbl[tbl_addr_i] <= tbl_wdata_i;
  end
  // sequencer state, duration counter and registered generator outputs
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state <= IDLE;
      cnt <= '0;
      cur_dur <= '0;
      step_o <= '0;
      empty <= 1'b0;
      tone_en_o <= 1'b0;
      tone_div_o <= '0;
      busy_o <= 1'b0;
      src_o <= 1'b0;
    end else begin
      state <= ns;
      cnt <= (ns != state || load) ? '0 : cnt + DUR_W'(tick_i);
      if (load) begin
        step_o <= use_c ? cand : '0;
        empty <= !ld_ok;
        cur_dur <= ld_ent[DIV_W+:DUR_W];
      end
      tone_en_o <= load ? ld_ok && ld_ent[DIV_W-1:0] != '0 : (ns == NOTE && tone_en_o) || ns_click;
      tone_div_o <= (load && ld_ok) ? ld_ent[DIV_W-1:0] : ns_click ? CLICK_DIV : tone_div_o;
      busy_o <= ns != IDLE;
      src_o <= ns_click;
    end
  end
  // sticky record of any rejected click
  always_ff @(posedge pclk_i) begin
    if (prst_i) click_drop_o <= 1'b0;
    else click_drop_o <= click_drop_o | drop_set;
  end
endmodule

// File: tb/tb_alarm_tone_seq.sv
// tb_alarm_tone_seq: directed stimulus with a per-cycle behavioural model check of alarm_tone_seq
module tb_alarm_tone_seq;
  logic pclk_i = 0, prst_i = 1, tick_i = 0, alarm_req_i = 0, click_req_i = 0, tbl_we_i = 0;
  logic [2:0] tbl_addr_i = '0;
  logic [31:0] tbl_wdata_i = '0;
  logic tone_en_o, busy_o, src_o, click_drop_o;
  logic [15:0] tone_div_o;
  logic [2:0] step_o;
  int checks = 0, errors = 0;
`ifdef ALARM_SEQ_CLICK_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  localparam int IDLEM = 0, NOTEM = 1, GAPM = 2, CLKM = 3;
  int m_mode = IDLEM, m_rem = 0, tc = 0;
  logic [2:0] m_step = '0;
  logic [15:0] m_div = '0;
  bit m_drop = 0, m_empty = 0, mvalid = 0, exp_en;
  logic [31:0] m_tbl [8];

  alarm_tone_seq dut (
    .pclk_i(pclk_i), .prst_i(prst_i), .tick_i(tick_i), .alarm_req_i(alarm_req_i),
    .click_req_i(click_req_i), .tbl_we_i(tbl_we_i), .tbl_addr_i(tbl_addr_i),
    .tbl_wdata_i(tbl_wdata_i), .tone_en_o(tone_en_o), .tone_div_o(tone_div_o),
    .busy_o(busy_o), .src_o(src_o), .step_o(step_o), .click_drop_o(click_drop_o)
  );

  always #5 pclk_i = ~pclk_i;

  initial forever begin
    @(posedge pclk_i);
    #1;
    tc = (tc + 1) % 4;
    tick_i = tc == 0;
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_start(int from);
    int idx;
    idx = m_tbl[from][31:16] != 0 ? from : m_tbl[0][31:16] != 0 ? 0 : -1;
    if (idx < 0) begin
      m_mode = GAPM; m_step = 0; m_empty = 1;
    end else begin
      m_mode = NOTEM; m_step = 3'(idx); m_rem = int'(m_tbl[idx][31:16]);
      m_div = m_tbl[idx][15:0]; m_empty = 0;
    end
  endtask

  always @(negedge pclk_i) begin
    if (mvalid) begin
      exp_en = (m_mode == NOTEM && m_div != 0) || m_mode == CLKM;
      chk("m_en", 32'(tone_en_o), 32'(exp_en));
      chk("m_busy", 32'(busy_o), 32'(m_mode != IDLEM));
      chk("m_src", 32'(src_o), 32'(m_mode == CLKM));
      chk("m_drop", 32'(click_drop_o), 32'(m_drop));
      if (exp_en) chk("m_div", 32'(tone_div_o), 32'(m_div));
      if (m_mode == NOTEM || m_mode == GAPM) chk("m_step", 32'(step_o), 32'(m_step));
    end
    if (prst_i) begin
      m_mode = IDLEM; m_div = 0; m_step = 0; m_drop = 0; m_empty = 0; m_rem = 0;
      for (int i = 0; i < 8; i++) m_tbl[i] = '0;
      mvalid = 1;
    end else begin
      if (CEN && click_req_i && (m_mode != IDLEM || alarm_req_i)) m_drop = 1;
      if (m_mode == IDLEM || m_mode == CLKM) begin
        if (alarm_req_i) m_start(0);
        else if (m_mode == IDLEM) begin
          if (CEN && click_req_i) begin m_mode = CLKM; m_rem = 4; m_div = 500; end
        end else if (tick_i) begin
          m_rem--;
          if (m_rem == 0) m_mode = IDLEM;
        end
      end else if (!alarm_req_i) m_mode = IDLEM;
      else if (tick_i) begin
        if (m_mode == NOTEM) begin
          m_rem--;
          if (m_rem == 0) m_mode = GAPM;
        end else m_start(m_empty ? 0 : (int'(m_step) + 1) % 8);
      end
      if (tbl_we_i) m_tbl[tbl_addr_i] = tbl_wdata_i;
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge pclk_i); #1; end
  endtask

  task automatic wr(int a, int dur, int div);
    tbl_we_i = 1; tbl_addr_i = 3'(a); tbl_wdata_i = {16'(dur), 16'(div)};
    cyc();
    tbl_we_i = 0;
  endtask

  task automatic wait_ticks(int k);
    while (k > 0) begin @(posedge pclk_i); if (tick_i) k--; end
    #1;
  endtask

  initial begin
    int b;
    cyc(2);
    @(negedge pclk_i);
    chk("rst_en", 32'(tone_en_o), 0); chk("rst_div", 32'(tone_div_o), 0);
    chk("rst_busy", 32'(busy_o), 0); chk("rst_src", 32'(src_o), 0);
    chk("rst_step", 32'(step_o), 0); chk("rst_drop", 32'(click_drop_o), 0);
    cyc(); prst_i = 0;
    wr(0, 3, 100); wr(1, 2, 0); wr(2, 0, 55);
    alarm_req_i = 1; cyc(); @(negedge pclk_i);
    chk("t1_en", 32'(tone_en_o), 1); chk("t1_div", 32'(tone_div_o), 100); chk("t1_step", 32'(step_o), 0);
    wait_ticks(3); @(negedge pclk_i);
    chk("t1_gap_en", 32'(tone_en_o), 0); chk("t1_gap_busy", 32'(busy_o), 1);
    wait_ticks(1); @(negedge pclk_i);
    chk("t1_rest_step", 32'(step_o), 1); chk("t1_rest_en", 32'(tone_en_o), 0);
    wait_ticks(3); @(negedge pclk_i);
    chk("t1_wrap_step", 32'(step_o), 0); chk("t1_wrap_div", 32'(tone_div_o), 100);
    chk("t1_wrap_en", 32'(tone_en_o), 1);
    alarm_req_i = 0; cyc(2);
    for (int i = 0; i < 8; i++) wr(i, 1, 10 + i);
    alarm_req_i = 1; cyc(); @(negedge pclk_i);
    for (int i = 0; i < 9; i++) begin
      chk("t2_step", 32'(step_o), 32'(i % 8));
      chk("t2_div", 32'(tone_div_o), 32'(10 + i % 8));
      wait_ticks(2); @(negedge pclk_i);
    end
    alarm_req_i = 0; cyc(2);
`ifdef ALARM_SEQ_CLICK_EN
    click_req_i = 1; cyc(); click_req_i = 0; @(negedge pclk_i);
    chk("t3_src", 32'(src_o), 1); chk("t3_div", 32'(tone_div_o), 500); chk("t3_en", 32'(tone_en_o), 1);
    wait_ticks(4); @(negedge pclk_i);
    chk("t3_busy", 32'(busy_o), 0); chk("t3_idle_en", 32'(tone_en_o), 0);
    cyc(2);
    click_req_i = 1; cyc(); click_req_i = 0; cyc(2);
    alarm_req_i = 1; cyc(); @(negedge pclk_i);
    chk("t4_src", 32'(src_o), 0); chk("t4_div", 32'(tone_div_o), 10); chk("t4_step", 32'(step_o), 0);
    chk("t4_nodrop", 32'(click_drop_o), 0);
    cyc(); click_req_i = 1; cyc(); click_req_i = 0; @(negedge pclk_i);
    chk("t4_drop", 32'(click_drop_o), 1); chk("t4_busy", 32'(busy_o), 1);
    cyc(6);
`else
    click_req_i = 1; cyc(); click_req_i = 0; @(negedge pclk_i);
    chk("t3_busy", 32'(busy_o), 0); chk("t3_src", 32'(src_o), 0);
    chk("t3_en", 32'(tone_en_o), 0); chk("t3_drop", 32'(click_drop_o), 0);
    alarm_req_i = 1; cyc(6);
`endif
    b = 0;
    @(negedge pclk_i);
    while (!tone_en_o && b < 50) begin @(negedge pclk_i); b++; end
    chk("t5_note_seen", 32'(b < 50), 1);
    cyc(); alarm_req_i = 0; cyc(); @(negedge pclk_i);
    chk("t5_off_en", 32'(tone_en_o), 0); chk("t5_off_busy", 32'(busy_o), 0);
    cyc(4); alarm_req_i = 1; cyc(); @(negedge pclk_i);
    chk("t5_replay_step", 32'(step_o), 0); chk("t5_replay_div", 32'(tone_div_o), 10);
    chk("t5_replay_en", 32'(tone_en_o), 1);
    cyc(7);
    prst_i = 1; alarm_req_i = 0; cyc(); @(negedge pclk_i);
    chk("t6_en", 32'(tone_en_o), 0); chk("t6_div", 32'(tone_div_o), 0); chk("t6_busy", 32'(busy_o), 0);
    chk("t6_src", 32'(src_o), 0); chk("t6_step", 32'(step_o), 0); chk("t6_drop", 32'(click_drop_o), 0);
    cyc(); prst_i = 0; alarm_req_i = 1; cyc(); @(negedge pclk_i);
    chk("t6_empty_busy", 32'(busy_o), 1); chk("t6_empty_en", 32'(tone_en_o), 0);
    wait_ticks(3); @(negedge pclk_i);
    chk("t6_empty_busy2", 32'(busy_o), 1); chk("t6_empty_step", 32'(step_o), 0);
    alarm_req_i = 0; cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_tone_seq.md
# alarm_tone_seq

Tone scheduler between the alarm control logic and the audio PWM tone generator that drives `aud_pwm`. Shares the single tone generator between two requesters, a looping alarm melody and a short key-click, with the alarm having priority. Each cycle it hands the generator a registered enable and half-period divider, and it sequences melody steps from an 8-entry programmable note table on a slow tick timebase.

## Interface
- `NUM_STEPS`, 8 — melody table depth, power of two.
- `DIV_W`, 16 — tone half-period divider width.
- `DUR_W`, 16 — note duration width, in ticks.
- `CLICK_DIV`, 16'd500 — divider used for the key-click.
- `CLICK_TICKS`, 4 — key-click length, in ticks.

Ports:
- `pclk_i` in 1 — clock; the only clock in the block.
- `prst_i` in 1 — reset; synchronous and active-high.
- `tick_i` in 1 — one-cycle duration strobe (1 ms timebase).
- `alarm_req_i` in 1 — level; melody plays while high.
- `click_req_i` in 1 — one-cycle click request.
- `tbl_we_i` in 1 — table write strobe.
- `tbl_addr_i` in $clog2(NUM_STEPS) — table entry index.
- `tbl_wdata_i` in DIV_W+DUR_W — `{dur, div}`.
- `tone_en_o` out 1 — tone generator enable.
- `tone_div_o` out DIV_W — tone generator half-period divider.
- `busy_o` out 1 — state is not IDLE.
- `src_o` out 1 — current source: 0 = alarm, 1 = click.
- `step_o` out $clog2(NUM_STEPS) — current melody step.
- `click_drop_o` out 1 — sticky; a click was rejected. Cleared by reset only.

## Operation
- States and transitions:
  - IDLE → ALARM when `alarm_req_i` is high.
  - IDLE → CLICK when `click_req_i` is high.
  - CLICK → ALARM on `alarm_req_i` (preempt); CLICK → IDLE after `CLICK_TICKS` ticks.
  - ALARM_NOTE → ALARM_GAP after `dur` ticks.
  - ALARM_GAP → ALARM_NOTE after 1 tick, loading the next step.
  - Any ALARM state → IDLE when `alarm_req_i` is low.
- Simultaneous `alarm_req_i` and `click_req_i` in IDLE: alarm wins; the click is dropped and `click_drop_o` is set.
- A click arriving in CLICK or any ALARM state is dropped and sets `click_drop_o`. Clicks are never queued.
- Step load:
  - The entry is latched into working registers on entry to ALARM_NOTE.
  - Table writes affect only entries loaded later.
  - A write and a load of the same entry in the same cycle: the load sees the old value.
- `div == 0`: the step is a rest, with `tone_en_o` = 0 for its duration.
- `dur == 0`: end-of-melody marker; the sequencer wraps to step 0.
- After step `NUM_STEPS-1`, the sequencer wraps to step 0.
- Step 0 with `dur == 0` (empty melody): stay in ALARM_GAP with tone off and `busy_o` = 1, re-checking step 0 every tick.
- ALARM_GAP: `tone_en_o` = 0 and `tone_div_o` holds the previous value.
- Duration counter:
  - Counts `tick_i` pulses and is cleared on every state entry.
  - A tick coinciding with state entry is not counted.

## Timing
- All outputs are registered.
- Reset values: `tone_en_o` = 0, `tone_div_o` = 0, `busy_o` = 0, `src_o` = 0, `step_o` = 0, `click_drop_o` = 0; table entries = 0; state = IDLE.
- Request in cycle N → `tone_en_o`, `tone_div_o` and `src_o` valid in cycle N+1.
- `alarm_req_i` falling in cycle N → `tone_en_o` = 0 and `busy_o` = 0 in cycle N+1, from any state.
- Note length is exactly `dur` ticks, followed by one gap tick.
- Reset asserted mid-melody: the next cycle shows all reset values, and the table is cleared.

## Configuration
- `ALARM_SEQ_CLICK_EN` defined: the CLICK state, click counter and drop logic are present.
- Undefined:
  - `click_req_i` is ignored.
  - `src_o` and `click_drop_o` are tied to 0.
  - The FSM has only IDLE, ALARM_NOTE and ALARM_GAP.

## Test plan
- Reset, then hold `alarm_req_i` with table `{dur, div}` = `{3, 100}`, `{2, 0}`, `{0, x}` → div 100 for 3 ticks, gap 1, rest 2 ticks, gap 1, then wrap to step 0 with div 100.
- Fill all 8 entries with `dur` = 1 and div `10..17` → steps 0–7 play and wrap to 0 after step 7; `step_o` sequence checked.
- Click pulse in IDLE → `src_o` = 1, div 500 for 4 ticks, then IDLE; `busy_o` = 0.
- Alarm raised during a click → next cycle `src_o` = 0 with step-0 div. Click during alarm → `click_drop_o` = 1 and melody unaffected.
- Drop `alarm_req_i` mid-note, then reassert after 5 cycles → tone off next cycle; replay starts at step 0.
- Assert `prst_i` mid-melody → all outputs zero next cycle; a following alarm request plays the empty melody (silent, `busy_o` = 1).
